hs_pipe_fifo: RTL and testbench

- Parametrised valid/ready buffer for the on-chip point-to-point bus.
- Sits between a bus source and a bus sink, decoupling their stalls.
- Generalises the single-beat handshake to configurable data width and buffer depth.
- Transfers are lossless and in order.
- No combinational path from m_ready to s_ready, and none from s_valid to m_valid.

---
 rtl/hs_bus_pkg.sv | 16 +
 rtl/hs_fifo_mem.sv | 26 ++
 rtl/hs_pipe_fifo.sv | 111 +++++++++++
 tb/tb_hs_pipe_fifo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/hs_bus_pkg.sv
// Shared definitions for the point-to-point bus buffers: default payload
// width, default buffer depth and a constant-foldable ceil(log2) helper.
package hs_bus_pkg;

   localparam int HS_DATA_W = 8;
   localparam int HS_DEPTH  = 4;

   // Smallest r with 2**r >= value; usable in parameter expressions.
   function automatic int hs_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// DEPTH x DATA_W register array with one synchronous write port and one
// asynchronous read port. Contents are not reset; the controller never
// presents an entry that has not been written since reset.
module hs_fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Store the incoming beat in the addressed slot.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/hs_pipe_fifo.sv
// Valid/ready buffer between a bus source and sink. First-word-fall-through
// output, one cycle of latency, no combinational paths across the buffer:
// s_ready and m_valid are decoded from the occupancy register only.
// Optional statistics counters are built when HS_PIPE_FIFO_STALL_CNT_EN
// is defined.
module hs_pipe_fifo
   import hs_bus_pkg::*;
#(
   parameter  int DATA_W = HS_DATA_W,
   parameter  int DEPTH  = HS_DEPTH,
   localparam int CNT_W  = hs_clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef HS_PIPE_FIFO_STALL_CNT_EN
   input  logic              stat_clr,
   output logic [15:0]       stall_cnt,
   output logic [15:0]       full_cnt,
`endif
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = hs_clog2(DEPTH);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push, pop;
   logic [DATA_W-1:0] rd_data;

   assign s_ready = (count_q != CNT_W'(DEPTH));
   assign m_valid = (count_q != '0);
   assign push    = s_valid & s_ready;
   assign pop     = m_valid & m_ready;
   assign count   = count_q;

   // Pointers wrap modulo DEPTH by overflow; occupancy moves only on
   // a push without a pop or a pop without a push.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state register; reset discards all buffered beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   hs_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata (s_data),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

   // Uninitialised memory is masked so m_data reads zero out of reset.
   assign m_data = m_valid ? rd_data : '0;

`ifdef HS_PIPE_FIFO_STALL_CNT_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] full_cnt_q;

   // Saturating event counters; stat_clr wins over an increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         full_cnt_q  <= '0;
      end else if (stat_clr) begin
         stall_cnt_q <= '0;
         full_cnt_q  <= '0;
      end else begin
         if (m_valid && !m_ready && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
         if (s_valid && !s_ready && (full_cnt_q != 16'hFFFF))
            full_cnt_q <= full_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign full_cnt  = full_cnt_q;
`endif

endmodule

// File: tb/tb_hs_pipe_fifo.sv
module tb_hs_pipe_fifo;
   import hs_bus_pkg::*;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = hs_clog2(DEPTH) + 1;

   logic              clk;
   logic              rst_n;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic [CNT_W-1:0]  count;
`ifdef HS_PIPE_FIFO_STALL_CNT_EN
   logic              stat_clr;
   logic [15:0]       stall_cnt;
   logic [15:0]       full_cnt;
   logic [15:0]       exp_stall;
   logic [15:0]       exp_full;
`endif

   int n_vec;
   int n_err;
   int sz;
   logic [DATA_W-1:0] exp_q[$];

   hs_pipe_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef HS_PIPE_FIFO_STALL_CNT_EN
      .stat_clr  (stat_clr),
      .stall_cnt (stall_cnt),
      .full_cnt  (full_cnt),
`endif
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: the reference model is a queue of accepted beats. Occupancy,
   // flags and head-of-line data are compared each cycle, then the transfers
   // implied by this cycle's inputs are applied to the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
`ifdef HS_PIPE_FIFO_STALL_CNT_EN
         exp_stall = '0;
         exp_full  = '0;
`endif
      end else begin
         sz = exp_q.size();
         chk("count", 32'(count), 32'(sz));
         chk("count_le_depth", 32'(count <= CNT_W'(DEPTH)), 32'd1);
         chk("m_valid", 32'(m_valid), 32'(sz != 0));
         chk("s_ready", 32'(s_ready), 32'(sz != DEPTH));
         if (sz != 0) chk("m_data", 32'(m_data), 32'(exp_q[0]));
`ifdef HS_PIPE_FIFO_STALL_CNT_EN
         chk("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
         chk("full_cnt", 32'(full_cnt), 32'(exp_full));
         if (stat_clr) begin
            exp_stall = '0;
            exp_full  = '0;
         end else begin
            if (sz != 0 && !m_ready && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
            if (s_valid && sz == DEPTH && exp_full != 16'hFFFF) exp_full = exp_full + 16'd1;
         end
`endif
         if (sz != 0 && m_ready) void'(exp_q.pop_front());
         if (s_valid && sz != DEPTH) exp_q.push_back(s_data);
      end
   end

   initial begin
      n_vec   = 0;
      n_err   = 0;
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b0;
`ifdef HS_PIPE_FIFO_STALL_CNT_EN
      stat_clr = 1'b0;
`endif
      #2;
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;

      // Idle
      repeat (5) tick();

      // Fill while the sink stalls, then offer one beat while full
      for (int i = 0; i < DEPTH; i++) begin
         s_valid = 1'b1;
         s_data  = DATA_W'(i + 1);
         tick();
      end
      s_data = 16'h0099;
      tick();
      s_valid = 1'b0;
      chk("full_count", 32'(count), 32'(DEPTH));
      chk("full_s_ready", 32'(s_ready), 32'd0);
      chk("full_head", 32'(m_data), 32'd1);
      repeat (3) tick();
      chk("full_head_hold", 32'(m_data), 32'd1);

      // Drain
      m_ready = 1'b1;
      repeat (DEPTH) tick();
      chk("drained_m_valid", 32'(m_valid), 32'd0);
      chk("drained_count", 32'(count), 32'd0);

      // Streaming with both sides always ready
      for (int i = 0; i < 20; i++) begin
         s_valid = 1'b1;
         s_data  = DATA_W'(i);
         tick();
         if (i == 10) chk("stream_count", 32'(count), 32'd1);
      end
      s_valid = 1'b0;
      tick();

      // Reset with three beats buffered
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1;
         s_data  = DATA_W'(16'h0A00 + i);
         tick();
      end
      s_valid = 1'b0;
      chk("pre_rst_count", 32'(count), 32'd3);
      rst_n = 1'b0;
      #1;
      chk("async_m_valid", 32'(m_valid), 32'd0);
      chk("async_count", 32'(count), 32'd0);
      chk("async_s_ready", 32'(s_ready), 32'd1);
      tick();
      tick();
      rst_n = 1'b1;
      s_valid = 1'b1;
      s_data  = 16'hABCD;
      tick();
      s_valid = 1'b0;
      chk("post_rst_data", 32'(m_data), 32'h0000ABCD);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;

`ifdef HS_PIPE_FIFO_STALL_CNT_EN
      // Ten stalled cycles, then clear
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      s_valid = 1'b1;
      s_data  = 16'h5555;
      tick();
      s_valid = 1'b0;
      repeat (10) tick();
      chk("stall_cnt_10", 32'(stall_cnt), 32'd10);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("stall_cnt_clr", 32'(stall_cnt), 32'd0);
      m_ready = 1'b1;
      tick();
`endif

      // Random traffic
      for (int i = 0; i < 1000; i++) begin
         s_valid = 1'($urandom_range(0, 1));
         s_data  = DATA_W'($urandom);
         m_ready = 1'($urandom_range(0, 1));
`ifdef HS_PIPE_FIFO_STALL_CNT_EN
         stat_clr = ($urandom_range(0, 63) == 0);
`endif
         tick();
      end
`ifdef HS_PIPE_FIFO_STALL_CNT_EN
      stat_clr = 1'b0;
`endif

      // Bounded final drain
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 4 * DEPTH && m_valid; i++) tick();
      tick();
      chk("final_m_valid", 32'(m_valid), 32'd0);
      chk("final_model_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
